pc_npc_bp: RTL and testbench

Parametrised program-counter unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the head of the fetch stage and predicts the next PC each cycle from the BTB. It also accepts resolved control-flow outcomes from EX, detects mispredictions, redirects the PC and trains the BTB. It supersedes the plain PC/next-PC block by moving control-flow resolution out to EX and adding prediction.

---
 rtl/pc_npc_bp.sv | 78 +++++++
 tb/tb_pc_npc_bp.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_npc_bp.sv
// pc_npc_bp: fetch PC register with a direct-mapped BTB and 2-bit direction counters.
// It predicts the next PC at fetch and is redirected and trained by resolved EX outcomes.
module pc_npc_bp #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] PC,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_ctrl,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [XLEN-1:0]  r_pc;
    logic             r_valid [BTB_ENTRIES];
    logic [1:0]       r_ctr   [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag   [BTB_ENTRIES];
    logic [XLEN-1:0]  r_tgt   [BTB_ENTRIES];

    logic [IDX_W-1:0] w_idx, w_ex_idx;
    logic             w_hit, w_ex_hit, w_train, w_unused;
    logic [XLEN-1:0]  w_corr, w_npc;

    assign w_unused = ex_pred_taken;
    assign PC       = r_pc;

    assign w_idx       = r_pc[IDX_W+1:2];
    assign w_hit       = r_valid[w_idx] && r_tag[w_idx] == r_pc[XLEN-1:IDX_W+2];
    assign pred_taken  = w_hit && r_ctr[w_idx][1];
    assign pred_target = pred_taken ? r_tgt[w_idx] : r_pc + XLEN'(4);

    assign w_ex_idx   = ex_pc[IDX_W+1:2];
    assign w_ex_hit   = r_valid[w_ex_idx] && r_tag[w_ex_idx] == ex_pc[XLEN-1:IDX_W+2];
    assign w_train    = ex_valid && ex_is_ctrl;
    assign w_corr     = ex_taken ? ex_target : ex_pc + XLEN'(4);
    // Comparing against the carried target catches both direction and target errors.
    assign mispredict = w_train && w_corr != ex_pred_target;
    assign w_npc      = mispredict ? w_corr : stall ? r_pc : pred_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else begin
            r_pc <= w_npc;
            if (w_train && w_ex_hit)
                r_ctr[w_ex_idx] <= ex_taken ? (r_ctr[w_ex_idx] == 2'b11 ? 2'b11 : r_ctr[w_ex_idx] + 2'd1)
                                            : (r_ctr[w_ex_idx] == 2'b00 ? 2'b00 : r_ctr[w_ex_idx] - 2'd1);
            else if (w_train && ex_taken) begin
                r_valid[w_ex_idx] <= 1'b1;
                r_ctr[w_ex_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target need no reset; a taken outcome always refreshes both (tag is unchanged on a hit).
    always_ff @(posedge clk) begin
        if (w_train && ex_taken) begin
            r_tag[w_ex_idx] <= ex_pc[XLEN-1:IDX_W+2];
            r_tgt[w_ex_idx] <= ex_target;
        end
    end
endmodule

// File: tb/tb_pc_npc_bp.sv
// tb_pc_npc_bp: directed vector table plus randomized traffic against a BTB reference model.
module tb_pc_npc_bp;
    logic        clk, rst, stall, ex_valid, ex_is_ctrl, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        pred_taken, mispredict;
    logic [31:0] PC, pred_target;

    pc_npc_bp #(.XLEN(32), .RESET_PC(32'h0000_0100), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .PC(PC),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    bit          m_v   [16];
    int          m_ctr [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [31:0] m_pc;

    bit          s_pt, s_mp;
    logic [31:0] s_ptg, s_pc;

    typedef struct {
        bit          s, v, c, t;
        logic [31:0] epc, etgt, eptgt;
        bit          xpt;
        logic [31:0] xptg;
        bit          xmp;
        logic [31:0] xpc;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0;
            m_ctr[i] = 1;
        end
        m_pc = 32'h100;
    endtask

    function automatic void m_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int i = int'((pc >> 2) % 16);
        t  = m_v[i] && m_tag[i] == (pc >> 6) && m_ctr[i] >= 2;
        tg = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    task automatic step(input bit s, v, c, t, input logic [31:0] epc, etgt, eptgt);
        bit          pt, mp, hit;
        logic [31:0] ptg, corr, npc;
        int          i;
        stall = s; ex_valid = v; ex_is_ctrl = c; ex_taken = t;
        ex_pc = epc; ex_target = etgt; ex_pred_target = eptgt; ex_pred_taken = 0;
        #1;
        m_pred(m_pc, pt, ptg);
        corr = t ? etgt : epc + 32'd4;
        mp   = v && c && corr != eptgt;
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, pt});
        chk("pred_target", pred_target, ptg);
        chk("mispredict", {31'd0, mispredict}, {31'd0, mp});
        s_pt = pred_taken; s_ptg = pred_target; s_mp = mispredict;
        npc = mp ? corr : s ? m_pc : ptg;
        i   = int'((epc >> 2) % 16);
        hit = m_v[i] && m_tag[i] == (epc >> 6);
        if (v && c) begin
            if (hit) begin
                m_ctr[i] = t ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
                if (t) m_tgt[i] = etgt;
            end else if (t) begin
                m_v[i] = 1; m_tag[i] = epc >> 6; m_tgt[i] = etgt; m_ctr[i] = 2;
            end
        end
        @(posedge clk);
        m_pc = npc;
        #1;
        chk("PC", PC, m_pc);
        s_pc = PC;
    endtask

    initial begin
        rst = 1; stall = 0; ex_valid = 0; ex_is_ctrl = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_target = 0;
        m_reset();
        #3;
        chk("reset PC", PC, 32'h100);
        chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset pred_target", pred_target, 32'h104);
        @(posedge clk);
        #1 rst = 0;

        //            s v c t  epc           etgt      eptgt     xpt xptg          xmp xpc
        tbl.push_back('{0,0,0,0, 32'h0,        32'h0,    32'h0,    0, 32'h104,      0, 32'h104});
        tbl.push_back('{0,0,0,0, 32'h0,        32'h0,    32'h0,    0, 32'h108,      0, 32'h108});
        tbl.push_back('{0,1,1,1, 32'h10,       32'h40,   32'h14,   0, 32'h10C,      1, 32'h40});
        tbl.push_back('{0,1,1,0, 32'h0C,       32'h0,    32'h20,   0, 32'h44,       1, 32'h10});
        tbl.push_back('{1,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h40,       0, 32'h10});
        tbl.push_back('{1,1,1,1, 32'h10,       32'h40,   32'h40,   1, 32'h40,       0, 32'h10});
        tbl.push_back('{0,1,1,0, 32'h10,       32'h0,    32'h40,   1, 32'h40,       1, 32'h14});
        tbl.push_back('{0,1,1,0, 32'h0C,       32'h0,    32'h20,   0, 32'h18,       1, 32'h10});
        tbl.push_back('{0,1,1,0, 32'h10,       32'h0,    32'h40,   1, 32'h40,       1, 32'h14});
        tbl.push_back('{0,1,1,0, 32'h0C,       32'h0,    32'h20,   0, 32'h18,       1, 32'h10});
        tbl.push_back('{1,1,1,0, 32'h10,       32'h0,    32'h14,   0, 32'h14,       0, 32'h10});
        tbl.push_back('{1,1,1,0, 32'h10,       32'h0,    32'h14,   0, 32'h14,       0, 32'h10});
        tbl.push_back('{0,1,1,1, 32'h10,       32'h40,   32'h14,   0, 32'h14,       1, 32'h40});
        tbl.push_back('{0,1,1,0, 32'h0C,       32'h0,    32'h20,   0, 32'h44,       1, 32'h10});
        tbl.push_back('{1,0,0,0, 32'h0,        32'h0,    32'h0,    0, 32'h14,       0, 32'h10});
        tbl.push_back('{0,1,1,1, 32'h20,       32'h80,   32'h24,   0, 32'h14,       1, 32'h80});
        tbl.push_back('{0,1,1,1, 32'h20,       32'h90,   32'h80,   0, 32'h84,       1, 32'h90});
        tbl.push_back('{0,1,1,0, 32'h1C,       32'h0,    32'h0,    0, 32'h94,       1, 32'h20});
        tbl.push_back('{1,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h90,       0, 32'h20});
        tbl.push_back('{1,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h90,       0, 32'h20});
        tbl.push_back('{1,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h90,       0, 32'h20});
        tbl.push_back('{1,1,1,1, 32'h300,      32'h200,  32'h304,  1, 32'h90,       1, 32'h200});
        tbl.push_back('{0,1,1,1, 32'h50,       32'h60,   32'h54,   0, 32'h204,      1, 32'h60});
        tbl.push_back('{0,1,1,0, 32'h0C,       32'h0,    32'h20,   0, 32'h64,       1, 32'h10});
        tbl.push_back('{1,0,0,0, 32'h0,        32'h0,    32'h0,    0, 32'h14,       0, 32'h10});
        tbl.push_back('{0,1,1,0, 32'hFFFFFFF8, 32'h0,    32'h0,    0, 32'h14,       1, 32'hFFFFFFFC});
        tbl.push_back('{0,0,0,0, 32'h0,        32'h0,    32'h0,    0, 32'h0,        0, 32'h0});
        tbl.push_back('{0,1,1,0, 32'hFFFFFFFC, 32'h0,    32'h0,    0, 32'h4,        0, 32'h4});

        foreach (tbl[k]) begin
            step(tbl[k].s, tbl[k].v, tbl[k].c, tbl[k].t, tbl[k].epc, tbl[k].etgt, tbl[k].eptgt);
            chk($sformatf("vec%0d pred_taken", k), {31'd0, s_pt}, {31'd0, tbl[k].xpt});
            chk($sformatf("vec%0d pred_target", k), s_ptg, tbl[k].xptg);
            chk($sformatf("vec%0d mispredict", k), {31'd0, s_mp}, {31'd0, tbl[k].xmp});
            chk($sformatf("vec%0d PC", k), s_pc, tbl[k].xpc);
        end

        for (int n = 0; n < 500; n++) begin
            bit          v, c, t, s, pt;
            logic [31:0] epc, etgt, eptgt, ptg;
            if (n == 250) begin
                #2 rst = 1;
                #1;
                m_reset();
                chk("async reset PC", PC, 32'h100);
                chk("async reset pred_taken", {31'd0, pred_taken}, 32'd0);
                chk("async reset pred_target", pred_target, 32'h104);
                rst = 0;
            end
            s    = $urandom_range(0, 3) == 0;
            v    = $urandom_range(0, 4) != 0;
            c    = $urandom_range(0, 3) != 0;
            t    = $urandom_range(0, 1) == 1;
            epc  = ($urandom_range(0, 3) == 0) ? {$urandom, 2'b00} : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            etgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            m_pred(epc, pt, ptg);
            eptgt = ($urandom_range(0, 1) == 1) ? ptg : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            step(s, v, c, t, epc, etgt, eptgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
